// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters (CPU data port m0, DMA/loader m1),
// the data-memory arbiter and the single-port data memory.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic              m0_err;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic              m1_err;
    logic [DATA_W-1:0] m1_rdata;

    logic              mem_cs;
    logic              mem_w;
    logic              mem_r;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Requester/memory side of the bundle
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_err, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_err, m1_rdata,
        input  mem_cs, mem_w, mem_r, mem_addr, mem_wdata,
        output mem_rdata
    );

    // Arbiter side of the bundle
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_err, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_err, m1_rdata,
        output mem_cs, mem_w, mem_r, mem_addr, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port data memory between
// the CPU data port (m0) and the DMA/loader port (m1): arbitrate, access, respond.
module dmem_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_WORDS = 2048
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    localparam int unsigned WIDX_W = ADDR_W - 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              sel_q, sel_d;
    logic              last_q, last_d;
    logic              err_q, err_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              err0_q, err0_d;
    logic              err1_q, err1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic              win_c;
    logic              oor0_c;
    logic              oor1_c;
    logic              sel_we_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_wdata_c;
    logic [DATA_W-1:0] acc_rdata_c;
    logic              access_c;

    function automatic logic out_of_range(input logic [WIDX_W-1:0] widx);
        return widx >= WIDX_W'(MEM_WORDS);
    endfunction

    // Request decode: tie goes to the master that was not served last
    always_comb begin
        win_c  = (bus.m0_req && bus.m1_req) ? ~last_q : bus.m1_req;
        oor0_c = out_of_range(bus.m0_addr[ADDR_W-1:2]);
        oor1_c = out_of_range(bus.m1_addr[ADDR_W-1:2]);
    end

    // Granted master's request fields
    always_comb begin
        sel_we_c    = sel_q ? bus.m1_we    : bus.m0_we;
        sel_addr_c  = sel_q ? bus.m1_addr  : bus.m0_addr;
        sel_wdata_c = sel_q ? bus.m1_wdata : bus.m0_wdata;
        acc_rdata_c = (err_q || sel_we_c) ? '0 : bus.mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sel_q    <= 1'b0;
            last_q   <= 1'b1;
            err_q    <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            err_q    <= err_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Next-state and registered response logic
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        last_d   = last_q;
        err_d    = err_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    state_d = S_ACC;
                    sel_d   = win_c;
                    err_d   = win_c ? oor1_c : oor0_c;
                end
            end
            S_ACC: begin
                state_d = S_RESP;
                last_d  = sel_q;
                if (sel_q) begin
                    ack1_d   = 1'b1;
                    err1_d   = err_q;
                    rdata1_d = acc_rdata_c;
                end else begin
                    ack0_d   = 1'b1;
                    err0_d   = err_q;
                    rdata0_d = acc_rdata_c;
                end
            end
            S_RESP: begin
                // sel still holds req this cycle, so only the other master may be granted
                if (sel_q ? bus.m0_req : bus.m1_req) begin
                    state_d = S_ACC;
                    sel_d   = ~sel_q;
                    err_d   = sel_q ? oor0_c : oor1_c;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Memory strobes; gated by reset so an aborted access cannot commit
    always_comb begin
        access_c      = (state_q == S_ACC) && !err_q;
        bus.mem_cs    = access_c && !reset;
        bus.mem_w     = access_c && sel_we_c && !reset;
        bus.mem_r     = access_c && !sel_we_c && !reset;
        bus.mem_addr  = access_c ? sel_addr_c  : '0;
        bus.mem_wdata = access_c ? sel_wdata_c : '0;
    end

    assign bus.m0_ack   = ack0_q;
    assign bus.m0_err   = err0_q;
    assign bus.m0_rdata = rdata0_q;
    assign bus.m1_ack   = ack1_q;
    assign bus.m1_err   = err1_q;
    assign bus.m1_rdata = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port data memory.
module tb_dmem_arbiter;
    logic clk;
    logic reset;
    logic preload;
    int   checks;
    int   errors;

    logic [31:0] mem [0:2047];

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_WORDS(2048)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Async read, write at posedge; preload seeds known contents once
    assign bus.mem_rdata = mem[bus.mem_addr[12:2]];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 32'h0;
            mem[0]    <= 32'h0BADF00D;
            mem[4]    <= 32'hDEADBEEF;
            mem[5]    <= 32'h55667788;
            mem[16]   <= 32'h01020304;
        end else if (bus.mem_cs && bus.mem_w) begin
            mem[bus.mem_addr[12:2]] <= bus.mem_wdata;
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_cs"},    32'(bus.mem_cs), 32'h0);
        check({tag, "_w"},     32'(bus.mem_w), 32'h0);
        check({tag, "_r"},     32'(bus.mem_r), 32'h0);
        check({tag, "_addr"},  bus.mem_addr, 32'h0);
        check({tag, "_wdata"}, bus.mem_wdata, 32'h0);
        check({tag, "_ack0"},  32'(bus.m0_ack), 32'h0);
        check({tag, "_ack1"},  32'(bus.m1_ack), 32'h0);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        preload     = 1'b1;
        bus.m0_req  = 1'b0;
        bus.m0_we   = 1'b0;
        bus.m0_addr = 32'h0;
        bus.m0_wdata = 32'h0;
        bus.m1_req  = 1'b0;
        bus.m1_we   = 1'b0;
        bus.m1_addr = 32'h0;
        bus.m1_wdata = 32'h0;

        tick();
        preload = 1'b0;
        tick();
        check_idle("rst");
        check("rst_rdata0", bus.m0_rdata, 32'h0);
        check("rst_rdata1", bus.m1_rdata, 32'h0);
        check("rst_err0", 32'(bus.m0_err), 32'h0);
        reset = 1'b0;
        tick();

        // Tie after reset: m0 first, then strict alternation while both held
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h10;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h14;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("tie_cs%0d", i),   32'(bus.mem_cs), 32'(i % 2));
            check($sformatf("tie_ack0_%0d", i), 32'(bus.m0_ack), 32'(i == 2 || i == 6));
            check($sformatf("tie_ack1_%0d", i), 32'(bus.m1_ack), 32'(i == 4 || i == 8));
            if (i == 1) check("tie_addr1", bus.mem_addr, 32'h10);
            if (i == 3) check("tie_addr3", bus.mem_addr, 32'h14);
            if (i == 2) check("tie_rdata0", bus.m0_rdata, 32'hDEADBEEF);
            if (i == 4) check("tie_rdata1", bus.m1_rdata, 32'h55667788);
        end
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        tick();
        check_idle("tie_end");

        // Single m0 read of word 4
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h10;
        tick();
        check("rd_cs",   32'(bus.mem_cs), 32'h1);
        check("rd_r",    32'(bus.mem_r), 32'h1);
        check("rd_w",    32'(bus.mem_w), 32'h0);
        check("rd_addr", bus.mem_addr, 32'h10);
        check("rd_ack_early", 32'(bus.m0_ack), 32'h0);
        tick();
        check("rd_ack",   32'(bus.m0_ack), 32'h1);
        check("rd_err",   32'(bus.m0_err), 32'h0);
        check("rd_rdata", bus.m0_rdata, 32'hDEADBEEF);
        check("rd_ack1",  32'(bus.m1_ack), 32'h0);
        check("rd_cs_resp", 32'(bus.mem_cs), 32'h0);
        bus.m0_req = 1'b0;
        tick();
        check("rd_ack_pulse", 32'(bus.m0_ack), 32'h0);

        // m1 writes the last word, m0 reads it back
        check("wr_w_before", 32'(bus.mem_w), 32'h0);
        bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h1FFC; bus.m1_wdata = 32'h12345678;
        tick();
        check("wr_cs",    32'(bus.mem_cs), 32'h1);
        check("wr_w",     32'(bus.mem_w), 32'h1);
        check("wr_r",     32'(bus.mem_r), 32'h0);
        check("wr_addr",  bus.mem_addr, 32'h1FFC);
        check("wr_wdata", bus.mem_wdata, 32'h12345678);
        tick();
        check("wr_w_after", 32'(bus.mem_w), 32'h0);
        check("wr_ack1",  32'(bus.m1_ack), 32'h1);
        check("wr_err1",  32'(bus.m1_err), 32'h0);
        check("wr_rdata1", bus.m1_rdata, 32'h0);
        check("wr_mem",   mem[2047], 32'h12345678);
        bus.m1_req = 1'b0;
        tick();
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h1FFC;
        tick();
        check("xrd_addr", bus.mem_addr, 32'h1FFC);
        tick();
        check("xrd_ack",   32'(bus.m0_ack), 32'h1);
        check("xrd_rdata", bus.m0_rdata, 32'h12345678);
        bus.m0_req = 1'b0;
        tick();

        // Out-of-range write: no memory activity, error response
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h2000; bus.m0_wdata = 32'hBAD0BAD0;
        tick();
        check("oor_cs_acc", 32'(bus.mem_cs), 32'h0);
        check("oor_w_acc",  32'(bus.mem_w), 32'h0);
        tick();
        check("oor_cs_resp", 32'(bus.mem_cs), 32'h0);
        check("oor_ack",   32'(bus.m0_ack), 32'h1);
        check("oor_err",   32'(bus.m0_err), 32'h1);
        check("oor_rdata", bus.m0_rdata, 32'h0);
        bus.m0_req = 1'b0;
        tick();
        check("oor_err_pulse", 32'(bus.m0_err), 32'h0);
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h0;
        tick();
        tick();
        check("oor_rb_ack",   32'(bus.m0_ack), 32'h1);
        check("oor_rb_rdata", bus.m0_rdata, 32'h0BADF00D);
        bus.m0_req = 1'b0;
        tick();

        // Reset during the access cycle of an m1 write
        bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h40; bus.m1_wdata = 32'hAAAA5555;
        tick();
        reset = 1'b1;
        #1;
        check("rst_acc_w",  32'(bus.mem_w), 32'h0);
        check("rst_acc_cs", 32'(bus.mem_cs), 32'h0);
        tick();
        check("rst_ack1",  32'(bus.m1_ack), 32'h0);
        check("rst_mem",   mem[16], 32'h01020304);
        bus.m1_req = 1'b0;
        reset = 1'b0;
        tick();
        check_idle("rst_after");

        // Tie right after reset again favours m0
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h40;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h14;
        tick();
        check("rtie_addr0", bus.mem_addr, 32'h40);
        tick();
        check("rtie_ack0",  32'(bus.m0_ack), 32'h1);
        check("rtie_ack1",  32'(bus.m1_ack), 32'h0);
        check("rtie_rdata0", bus.m0_rdata, 32'h01020304);
        bus.m0_req = 1'b0;
        tick();
        check("rtie_addr1", bus.mem_addr, 32'h14);
        tick();
        check("rtie_ack1b",  32'(bus.m1_ack), 32'h1);
        check("rtie_rdata1", bus.m1_rdata, 32'h55667788);
        bus.m1_req = 1'b0;
        tick();

        // Idle quiet: nothing moves, rdata registers hold
        for (int i = 0; i < 20; i++) begin
            tick();
            check_idle($sformatf("quiet%0d", i));
            check($sformatf("quiet_rd0_%0d", i), bus.m0_rdata, 32'h01020304);
            check($sformatf("quiet_rd1_%0d", i), bus.m1_rdata, 32'h55667788);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer that shares the single-port data memory (word-addressed, async read, write on posedge clk) between the CPU data port (m0) and the DMA/loader port (m1).
- Each access takes a fixed 3-phase sequence: arbitrate, drive memory strobes for exactly one cycle, return a registered response.
- Round-robin grant, out-of-range address checking, and per-master ack/error responses.

Parameters:
- ADDR_W, 32, byte address width on all ports.
- DATA_W, 32, data width.
- MEM_WORDS, 2048, memory depth in words. Word index = addr[ADDR_W-1:2]; an index >= MEM_WORDS is out of range.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  1  CPU request. Held high, with m0_we/addr/wdata stable, until m0_ack.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- m0_wdata  in  DATA_W  write data.
- m0_ack  out  1  one-cycle completion pulse.
- m0_err  out  1  valid with m0_ack; 1 = out-of-range, no access performed.
- m0_rdata  out  DATA_W  read data, valid with m0_ack.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata  same as m0_*, for the DMA/loader port.
- mem_cs  out  1  memory chip select.
- mem_w  out  1  memory write strobe.
- mem_r  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory async read data.

Behaviour:
- State machine: IDLE, ACC, RESP. Registers: state, sel (granted master), last (last granted master), latched err flag, rdata register, ack registers.
- Reset values:
  - state = IDLE, last = 1 (so m0 wins the first tie).
  - All acks, errs and rdata = 0.
  - All mem_* outputs = 0.
- IDLE:
  - If any req is high, pick a winner and go to ACC.
  - Winner: the single requester if only one; on a tie, the master != last.
  - Latch sel, and set err = (word index >= MEM_WORDS) for the winner's address.
- ACC, one cycle only:
  - If !err: mem_cs=1, mem_addr/mem_wdata = the sel master's inputs, mem_w=we, mem_r=!we. The write commits at the closing edge of this cycle.
  - If err: all mem_* = 0.
  - At the closing edge: capture mem_rdata into the sel master's rdata register (0 for writes or err), last <= sel, go to RESP.
- RESP:
  - Assert ack (and err if latched) for sel for exactly this cycle.
  - Re-arbitrate excluding sel, because sel's req is still high this cycle. If the other master's req is high, go directly to ACC with it granted; otherwise go to IDLE.
- Latency: req first seen high in cycle N → mem access in N+1 → ack in N+2.
  - Back-to-back alternating masters: one access per 2 cycles.
  - Same master repeatedly: one access per 3 cycles.
- mem_* outputs are combinational from state/sel and equal 0 outside ACC.
- rdata holds its value after ack until the next ack to that master. Only the acked master's rdata is updated.
- A req dropped before ack is a protocol violation; the arbiter still completes the latched transaction.
- Reset in any state, including ACC:
  - mem_cs/mem_w are gated by !reset that same cycle, so no write commits.
  - The next state is IDLE and no ack is issued for the aborted transaction.
- Address bits [1:0] are passed through on mem_addr unchanged; memory ignores them.

Test Plan:
- Single read: m0 read at 0x10, memory word 4 = 0xDEADBEEF.
  → mem_cs=mem_r=1 with mem_addr=0x10 in N+1; m0_ack=1, m0_err=0, m0_rdata=0xDEADBEEF in N+2; m1_ack stays 0.
- Tie after reset: m0 and m1 both request in the same cycle.
  → m0 is accessed first (ack N+2), then m1 via RESP→ACC (ack N+4).
  → With both reqs held continuously, grants alternate m0, m1, m0, m1.
- Cross-port coherence: m1 writes 0x12345678 to 0x1FFC (word 2047).
  → mem_w=1 for exactly one cycle and m1_ack follows.
  → A subsequent m0 read of 0x1FFC returns 0x12345678.
- Out-of-range: m0 write to 0x2000 (word 2048).
  → mem_cs stays 0 throughout; m0_ack=1 and m0_err=1 in N+2; word 0 is unchanged on readback.
- Reset mid-access: assert reset during the ACC cycle of an m1 write of 0xAAAA5555 to 0x40.
  → mem_w stays 0 and no ack is issued; state returns to IDLE; readback of 0x40 shows the old value.
  → A m0/m1 tie after reset grants m0 first.
- Idle quiet: no reqs for 20 cycles.
  → All mem_* outputs are 0, no acks, and rdata registers keep their last values.
